// File: rtl/aemb2_pipe_sched_if.sv
// ---------------------------------------------------------------------------
// aemb2_pipe_sched_if
//   Bus-wait handshake bundle seen by the AEMB2 pipeline sequencer.
//   iwb_stb / iwb_ack : instruction fetch pending / complete
//   dwb_stb / dwb_ack : EX data access pending / complete
//   master : bus side, drives all four signals
//   slave  : sequencer side, observes all four signals
// ---------------------------------------------------------------------------
interface aemb2_pipe_sched_if;
  logic iwb_stb;
  logic iwb_ack;
  logic dwb_stb;
  logic dwb_ack;

  modport master (output iwb_stb, iwb_ack, dwb_stb, dwb_ack);
  modport slave  (input  iwb_stb, iwb_ack, dwb_stb, dwb_ack);
endinterface

// File: rtl/aemb2_pipe_sched.sv
// ---------------------------------------------------------------------------
// aemb2_pipe_sched
//   Pipeline sequencer for the AEMB2 core. Produces the global pipeline
//   enable and the hardware-thread phase, inserts a one-cycle bubble for
//   load-use hazards, stalls for multi-cycle divides and freezes everything
//   while the instruction or data bus is waiting.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-low reset
//   bus_if      iwb/dwb strobe and acknowledge (slave modport)
//   rOPC_IF     opcode in IF/OF
//   rRA_IF      RA field in IF/OF
//   rRB_IF      RB field in IF/OF
//   rRD_EX      destination register in EX
//   rOPD_EX     EX result source: 0 ALU, 1 load, 2 other, 3 none
//   rMSR_TXE    thread-interleave enable from MSR
//   pha_o       thread phase (1 = thread 0)
//   ena_o       global pipeline advance
//   hold_if_o   hold IF/OF registers and inject a NOP into EX
//   div_busy_o  divide in progress
//   stall_o     stall cause: 0 none, 1 bus, 2 load-use, 3 divide
// ---------------------------------------------------------------------------
module aemb2_pipe_sched #(
  parameter int TXE    = 1,
  parameter int DIVCYC = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  aemb2_pipe_sched_if.slave  bus_if,
  input  logic [5:0]         rOPC_IF,
  input  logic [4:0]         rRA_IF,
  input  logic [4:0]         rRB_IF,
  input  logic [4:0]         rRD_EX,
  input  logic [1:0]         rOPD_EX,
  input  logic               rMSR_TXE,
  output logic               pha_o,
  output logic               ena_o,
  output logic               hold_if_o,
  output logic               div_busy_o,
  output logic [1:0]         stall_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_BUBL = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // The issue cycle is the first of DIVCYC EX cycles, so DIV lasts DIVCYC-1.
  localparam logic [5:0] DIV_LOAD = 6'(DIVCYC - 1);
  localparam logic [5:0] OPC_DIV  = 6'o22;
  localparam logic [1:0] OPD_LOAD = 2'd1;
  localparam logic       TXE_HW   = (TXE != 0);

  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_BUS  = 2'd1;
  localparam logic [1:0] STALL_LU   = 2'd2;
  localparam logic [1:0] STALL_DIV  = 2'd3;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       pha_q, pha_d;
  logic       ena_q, ena_d;
  logic       hold_q, hold_d;
  logic       busy_q, busy_d;
  logic [1:0] stall_q, stall_d;
  logic       post_bubl_q, post_bubl_d;

  logic bwait;
  logic ilv_on;
  logic load_use;
  logic div_issue;

  // Reset outranks a bus wait, so the wait is masked while rst_i is low.
  assign bwait = rst_i & ((bus_if.iwb_stb & ~bus_if.iwb_ack) |
                          (bus_if.dwb_stb & ~bus_if.dwb_ack));

  // With interleave active, neighbouring instructions belong to different
  // threads and can never form a load-use pair.
  assign ilv_on = TXE_HW & rMSR_TXE;

  // rOPC_IF[3] set means the B operand is an immediate, so RB is ignored.
  assign load_use = ~ilv_on && (rOPD_EX == OPD_LOAD) && (rRD_EX != 5'd0) &&
                    ((rRA_IF == rRD_EX) || (!rOPC_IF[3] && (rRB_IF == rRD_EX)));

  assign div_issue = (rOPC_IF == OPC_DIV);

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pha_d       = pha_q;
    ena_d       = ena_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    stall_d     = stall_q;
    post_bubl_d = post_bubl_q;

    if (!bwait) begin
      post_bubl_d = 1'b0;
      unique case (state_q)
        ST_RUN: begin
          // ena_q is low only in the single cycle right after reset release.
          if (ena_q) begin
            // Interleave off pulls a thread-1 phase back to thread 0.
            pha_d = ilv_on ? ~pha_q : 1'b1;
            if (load_use && !post_bubl_q) begin
              state_d = ST_BUBL;
            end else if (div_issue) begin
              state_d = ST_DIV;
              cnt_d   = DIV_LOAD;
            end
          end
        end
        ST_BUBL: begin
          // The load result is forwarded next cycle; skip one re-check.
          state_d     = ST_RUN;
          post_bubl_d = 1'b1;
        end
        ST_DIV: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase

      // Outputs are registered: decode them from the state being entered.
      ena_d   = (state_d != ST_DIV);
      hold_d  = (state_d == ST_BUBL);
      busy_d  = (state_d == ST_DIV);
      stall_d = (state_d == ST_BUBL) ? STALL_LU  :
                (state_d == ST_DIV)  ? STALL_DIV : STALL_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      cnt_q       <= 6'd0;
      pha_q       <= 1'b1;
      ena_q       <= 1'b0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      stall_q     <= STALL_NONE;
      post_bubl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pha_q       <= pha_d;
      ena_q       <= ena_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
      post_bubl_q <= post_bubl_d;
    end
  end

  assign pha_o      = pha_q;
  assign hold_if_o  = hold_q;
  assign div_busy_o = busy_q;
  // The bus wait is the only combinational path into the enable.
  assign ena_o      = ena_q & ~bwait;
  assign stall_o    = bwait ? STALL_BUS : stall_q;

endmodule

// File: tb/tb_aemb2_pipe_sched.sv
// ---------------------------------------------------------------------------
// tb_aemb2_pipe_sched
//   Self-checking bench for aemb2_pipe_sched (TXE=1, DIVCYC=32). Each cycle
//   the driver applies inputs on the falling edge and queues the expected
//   output word {pha, ena, hold_if, div_busy, stall[1:0]}; a monitor pops
//   and compares it 2 ns later, well before the next rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aemb2_pipe_sched;

  logic       clk_i;
  logic       rst_i;
  logic [5:0] rOPC_IF;
  logic [4:0] rRA_IF, rRB_IF, rRD_EX;
  logic [1:0] rOPD_EX;
  logic       rMSR_TXE;
  logic       pha_o, ena_o, hold_if_o, div_busy_o;
  logic [1:0] stall_o;

  aemb2_pipe_sched_if bus ();

  aemb2_pipe_sched #(.TXE(1), .DIVCYC(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus_if     (bus.slave),
    .rOPC_IF    (rOPC_IF),
    .rRA_IF     (rRA_IF),
    .rRB_IF     (rRB_IF),
    .rRD_EX     (rRD_EX),
    .rOPD_EX    (rOPD_EX),
    .rMSR_TXE   (rMSR_TXE),
    .pha_o      (pha_o),
    .ena_o      (ena_o),
    .hold_if_o  (hold_if_o),
    .div_busy_o (div_busy_o),
    .stall_o    (stall_o)
  );

  // Expected words {pha, ena, hold, busy, stall}.
  localparam logic [5:0] E_RST  = 6'b1_0_0_0_00; // reset / release cycle
  localparam logic [5:0] E_RUN1 = 6'b1_1_0_0_00; // running, thread 0
  localparam logic [5:0] E_RUN0 = 6'b0_1_0_0_00; // running, thread 1
  localparam logic [5:0] E_BUB1 = 6'b1_1_1_0_10; // load-use bubble
  localparam logic [5:0] E_DIV1 = 6'b1_0_0_1_11; // divide stall
  localparam logic [5:0] E_BWD1 = 6'b1_0_0_1_01; // bus wait during divide
  localparam logic [5:0] E_BW1  = 6'b1_0_0_0_01; // bus wait in RUN

  int n_checks = 0;
  int n_errors = 0;

  string      tag_q[$];
  logic [5:0] exp_q[$];

  // Staged stimulus, applied by cyc() on the falling edge.
  logic       s_rst, s_istb, s_iack, s_dstb, s_dack, s_txe;
  logic [5:0] s_opc;
  logic [4:0] s_ra, s_rb, s_rd;
  logic [1:0] s_opd;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input string tag, input logic [5:0] e);
    @(negedge clk_i);
    rst_i       = s_rst;
    bus.iwb_stb = s_istb;
    bus.iwb_ack = s_iack;
    bus.dwb_stb = s_dstb;
    bus.dwb_ack = s_dack;
    rOPC_IF     = s_opc;
    rRA_IF      = s_ra;
    rRB_IF      = s_rb;
    rRD_EX      = s_rd;
    rOPD_EX     = s_opd;
    rMSR_TXE    = s_txe;
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: compare each queued expectation mid-cycle.
  always @(negedge clk_i) begin
    #2;
    if (exp_q.size() != 0) begin
      check(tag_q.pop_front(), {26'd0, pha_o, ena_o, hold_if_o, div_busy_o, stall_o},
            {26'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_rst = 1'b0; s_istb = 1'b0; s_iack = 1'b0; s_dstb = 1'b0; s_dack = 1'b0;
    s_txe = 1'b1; s_opc = 6'o00; s_ra = 5'd1; s_rb = 5'd2; s_rd = 5'd0; s_opd = 2'd0;
    rst_i = 1'b0; bus.iwb_stb = 1'b0; bus.iwb_ack = 1'b0; bus.dwb_stb = 1'b0;
    bus.dwb_ack = 1'b0; rOPC_IF = 6'o00; rRA_IF = 5'd1; rRB_IF = 5'd2; rRD_EX = 5'd0;
    rOPD_EX = 2'd0; rMSR_TXE = 1'b1;

    // Reset held three cycles, then released; phase toggles 1,0,1,0.
    repeat (3) cyc("reset", E_RST);
    s_rst = 1'b1;
    cyc("release", E_RST);
    cyc("pha_a", E_RUN1);
    cyc("pha_b", E_RUN0);
    cyc("pha_c", E_RUN1);
    cyc("pha_d", E_RUN0);

    // Load-use on RA: one bubble, no re-check on the following cycle.
    s_txe = 1'b0; s_opd = 2'd1; s_rd = 5'd5; s_ra = 5'd5;
    cyc("lu_detect", E_RUN1);
    cyc("lu_bubble", E_BUB1);
    cyc("lu_after", E_RUN1);
    s_opd = 2'd0;
    cyc("lu_clear", E_RUN1);

    // Load into r0 is never a hazard.
    s_opd = 2'd1; s_rd = 5'd0; s_ra = 5'd0;
    cyc("lu_rd0_a", E_RUN1);
    cyc("lu_rd0_b", E_RUN1);

    // Interleave on: no hazard check, phase toggles.
    s_rd = 5'd5; s_ra = 5'd5; s_txe = 1'b1;
    cyc("lu_txe_a", E_RUN1);
    cyc("lu_txe_b", E_RUN0);
    cyc("lu_txe_c", E_RUN1);
    // Interleave drops while phase is 0: back to 1 and stays there.
    s_opd = 2'd0; s_txe = 1'b0;
    cyc("txe_fall_a", E_RUN0);
    cyc("txe_fall_b", E_RUN1);
    cyc("txe_fall_c", E_RUN1);

    // Immediate operand: RB match ignored; register form bubbles.
    s_opd = 2'd1; s_rd = 5'd7; s_rb = 5'd7; s_ra = 5'd3; s_opc = 6'o10;
    cyc("imm_a", E_RUN1);
    cyc("imm_b", E_RUN1);
    s_opc = 6'o00;
    cyc("reg_rb_detect", E_RUN1);
    cyc("reg_rb_bubble", E_BUB1);
    s_opd = 2'd0;
    cyc("reg_rb_clear", E_RUN1);

    // Divide: 31 stalled cycles after the issue cycle.
    s_ra = 5'd1; s_rb = 5'd2; s_rd = 5'd0; s_opc = 6'o22;
    cyc("div_issue", E_RUN1);
    s_opc = 6'o00;
    repeat (31) cyc("div_busy", E_DIV1);
    cyc("div_end", E_RUN1);

    // Divide with 4 bus-wait cycles in the middle: 35 stalled cycles.
    s_opc = 6'o22;
    cyc("divb_issue", E_RUN1);
    s_opc = 6'o00;
    repeat (10) cyc("divb_busy1", E_DIV1);
    s_dstb = 1'b1; s_dack = 1'b0;
    repeat (4) cyc("divb_bwait", E_BWD1);
    s_dstb = 1'b0;
    repeat (21) cyc("divb_busy2", E_DIV1);
    cyc("divb_end", E_RUN1);

    // Data bus wait with interleave on: phase frozen, enable back on ack.
    s_txe = 1'b1; s_dstb = 1'b1; s_dack = 1'b0;
    repeat (3) cyc("dwait", E_BW1);
    s_dack = 1'b1;
    cyc("dwait_ack", E_RUN1);
    s_dstb = 1'b0; s_dack = 1'b0;
    cyc("dwait_post", E_RUN0);
    // Instruction bus wait.
    s_istb = 1'b1; s_iack = 1'b0;
    cyc("iwait", E_BW1);
    s_iack = 1'b1;
    cyc("iwait_ack", E_RUN1);
    s_istb = 1'b0; s_iack = 1'b0;
    cyc("iwait_post", E_RUN0);
    s_txe = 1'b0;
    cyc("txe_off", E_RUN1);

    // Load-use and divide together: bubble first, divide issues after.
    s_opd = 2'd1; s_rd = 5'd4; s_ra = 5'd4; s_opc = 6'o22;
    cyc("pri_detect", E_RUN1);
    cyc("pri_bubble", E_BUB1);
    cyc("pri_issue", E_RUN1);
    s_opc = 6'o00; s_opd = 2'd0;
    // 22nd DIV cycle holds counter value 10.
    repeat (22) cyc("pri_busy", E_DIV1);

    // Asynchronous reset mid-divide, checked before any clock edge.
    #3;
    s_rst = 1'b0;
    rst_i = 1'b0;
    #1;
    check("rst_mid", {26'd0, pha_o, ena_o, hold_if_o, div_busy_o, stall_o}, {26'd0, E_RST});
    cyc("rst_hold", E_RST);
    s_rst = 1'b1;
    cyc("rst_release", E_RST);
    cyc("rst_run", E_RUN1);
    cyc("rst_run2", E_RUN1);

    #5;
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
